// File: rtl/network_pkg.sv
// -----------------------------------------------------------------------------
// network_pkg
// Shared definitions for the network sequencer slice.
//   seq_state_t : sequencer FSM state encoding
//   MAX_LAYERS  : largest supported number of chained conv layers
//   SYNC_STAGES : depth of the sample_clk synchronizer chain
//   LIDX_W      : width of the layer index register
// -----------------------------------------------------------------------------
package network_pkg;

    localparam int MAX_LAYERS  = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LIDX_W      = $clog2(MAX_LAYERS);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SHIFT_IN    = 3'd1,
        START_LAYER = 3'd2,
        WAIT_LAYER  = 3'd3,
        SHIFT_CACHE = 3'd4,
        OUTPUT      = 3'd5
    } seq_state_t;

endpackage

// File: rtl/network_sequencer_tick_sync.sv
// -----------------------------------------------------------------------------
// tick_sync
// Brings the asynchronous sample-rate strobe into the clk domain and turns
// each rising edge into a registered one-cycle tick. The tick appears three
// clk edges after the strobe edge (two synchronizer stages + edge register).
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   async_in in  asynchronous strobe
//   tick     out one-cycle pulse per rising edge of async_in
// -----------------------------------------------------------------------------
module tick_sync
    import network_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   tick_q;
    logic                   tick_d;

    // Shift the strobe through the synchronizer and detect its rising edge
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
        tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Synchronizer, edge history and tick registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/network_sequencer.sv
// -----------------------------------------------------------------------------
// network_sequencer
// Steps a chain of conv layers once per sample tick: shift the input buffers,
// start each layer in turn, wait for its done, clock the activation cache
// between layers, then latch the last layer's sample.
// Optional feature macro: SEQ_TIMEOUT_EN (per-layer watchdog, sticky error).
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   sample_clk   asynchronous sample-rate strobe
//   lsb_shift    pulse clocking the input shift buffers
//   conv_start   one-hot pulse starting conv k
//   conv_done    done strobes from the convs
//   cache_shift  one-hot pulse clocking activation cache k
//   final_in     signed sample from the last conv
//   sample_out   registered network output, out_valid pulses on update
//   busy         high while a pass is in flight
//   overrun_cnt  saturating count of ticks dropped while busy
//   pass_cycles  saturating length of the last completed pass
//   error        sticky watchdog flag (0 without SEQ_TIMEOUT_EN)
// All control outputs are registered from the current state, so they appear
// one cycle after the state that produces them.
// -----------------------------------------------------------------------------
module network_sequencer
    import network_pkg::*;
#(
    parameter int W          = 16,
    parameter int NUM_LAYERS = 3,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_clk,
    output logic                  lsb_shift,
    output logic [NUM_LAYERS-1:0] conv_start,
    input  logic [NUM_LAYERS-1:0] conv_done,
    output logic [NUM_LAYERS-2:0] cache_shift,
    input  logic signed [W-1:0]   final_in,
    output logic signed [W-1:0]   sample_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic [CNT_W-1:0]      overrun_cnt,
    output logic [CNT_W-1:0]      pass_cycles,
    output logic                  error
);

    localparam int NC = NUM_LAYERS - 1;
    localparam logic [LIDX_W-1:0]     LIDX_ZERO  = {LIDX_W{1'b0}};
    localparam logic [LIDX_W-1:0]     LIDX_ONE   = LIDX_W'(1);
    localparam logic [LIDX_W-1:0]     LAST_LIDX  = LIDX_W'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] START_ONE  = NUM_LAYERS'(1);
    localparam logic [NUM_LAYERS-1:0] START_ZERO = {NUM_LAYERS{1'b0}};
    localparam logic [NC-1:0]         CACHE_ONE  = NC'(1);
    localparam logic [NC-1:0]         CACHE_ZERO = {NC{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_MAX    = {CNT_W{1'b1}};

    seq_state_t              state_q, state_d;
    logic [LIDX_W-1:0]       lidx_q, lidx_d;
    logic                    lsb_shift_q, lsb_shift_d;
    logic [NUM_LAYERS-1:0]   conv_start_q, conv_start_d;
    logic [NC-1:0]           cache_shift_q, cache_shift_d;
    logic signed [W-1:0]     sample_out_q, sample_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic [CNT_W-1:0]        overrun_q, overrun_d;
    logic [CNT_W-1:0]        cyc_q, cyc_d;
    logic [CNT_W-1:0]        pass_q, pass_d;
    logic                    tick_s;
    logic                    done_sel_s;
    logic                    wdog_expire_s;

    tick_sync u_tick_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sample_clk),
        .tick     (tick_s)
    );

    // Only the done bit of the layer currently being waited on matters
    assign done_sel_s = |(conv_done & (START_ONE << lidx_q));

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            error_q, error_d;

    // Expiry on the last allowed wait cycle; a done in that cycle still wins
    assign wdog_expire_s = (state_q == WAIT_LAYER) && !done_sel_s && (wdog_q == WD_LAST);

    // Watchdog counts wait cycles of the current layer; error is sticky
    always_comb begin
        if (state_q == START_LAYER) begin
            wdog_d = WD_ZERO;
        end else if ((state_q == WAIT_LAYER) && !done_sel_s) begin
            wdog_d = wdog_q + WD_ONE;
        end else begin
            wdog_d = wdog_q;
        end
        if (wdog_expire_s) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q  <= WD_ZERO;
            error_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign wdog_expire_s = 1'b0;
    assign error         = 1'b0;
`endif

    // Next-state and layer index
    always_comb begin
        state_d = state_q;
        lidx_d  = lidx_q;
        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    state_d = SHIFT_IN;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT_IN: begin
                state_d = START_LAYER;
                lidx_d  = LIDX_ZERO;
            end
            START_LAYER: begin
                state_d = WAIT_LAYER;
            end
            WAIT_LAYER: begin
                if (done_sel_s) begin
                    if (lidx_q == LAST_LIDX) begin
                        state_d = OUTPUT;
                    end else begin
                        state_d = SHIFT_CACHE;
                    end
                end else if (wdog_expire_s) begin
                    state_d = IDLE;
                    lidx_d  = LIDX_ZERO;
                end else begin
                    state_d = WAIT_LAYER;
                end
            end
            SHIFT_CACHE: begin
                state_d = START_LAYER;
                lidx_d  = lidx_q + LIDX_ONE;
            end
            OUTPUT: begin
                state_d = IDLE;
                lidx_d  = LIDX_ZERO;
            end
            default: begin
                state_d = IDLE;
                lidx_d  = LIDX_ZERO;
            end
        endcase
    end

    // Output pulses, sample latch and statistics counters
    always_comb begin
        lsb_shift_d = (state_q == SHIFT_IN);
        out_valid_d = (state_q == OUTPUT);
        busy_d      = (state_d != IDLE);
        if (state_q == START_LAYER) begin
            conv_start_d = START_ONE << lidx_q;
        end else begin
            conv_start_d = START_ZERO;
        end
        if (state_q == SHIFT_CACHE) begin
            cache_shift_d = CACHE_ONE << lidx_q;
        end else begin
            cache_shift_d = CACHE_ZERO;
        end
        // cyc_q is 1 in SHIFT_IN; the recorded length also covers the
        // out_valid cycle that follows OUTPUT
        if (state_q == IDLE) begin
            cyc_d = CNT_ONE;
        end else if (cyc_q == CNT_MAX) begin
            cyc_d = cyc_q;
        end else begin
            cyc_d = cyc_q + CNT_ONE;
        end
        if (state_q == OUTPUT) begin
            sample_out_d = final_in;
            pass_d       = (cyc_q == CNT_MAX) ? CNT_MAX : cyc_q + CNT_ONE;
        end else begin
            sample_out_d = sample_out_q;
            pass_d       = pass_q;
        end
        if (tick_s && (state_q != IDLE) && (overrun_q != CNT_MAX)) begin
            overrun_d = overrun_q + CNT_ONE;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State, index and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lidx_q        <= LIDX_ZERO;
            lsb_shift_q   <= 1'b0;
            conv_start_q  <= START_ZERO;
            cache_shift_q <= CACHE_ZERO;
            sample_out_q  <= {W{1'b0}};
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= CNT_ZERO;
            cyc_q         <= CNT_ZERO;
            pass_q        <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            lidx_q        <= lidx_d;
            lsb_shift_q   <= lsb_shift_d;
            conv_start_q  <= conv_start_d;
            cache_shift_q <= cache_shift_d;
            sample_out_q  <= sample_out_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            cyc_q         <= cyc_d;
            pass_q        <= pass_d;
        end
    end

    assign lsb_shift   = lsb_shift_q;
    assign conv_start  = conv_start_q;
    assign cache_shift = cache_shift_q;
    assign sample_out  = sample_out_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign overrun_cnt = overrun_q;
    assign pass_cycles = pass_q;

endmodule

// File: tb/tb_network_sequencer.sv
// -----------------------------------------------------------------------------
// tb_network_sequencer
// Directed bench for network_sequencer. Two instances: a 3-layer one
// (TIMEOUT=16) and an 8-layer one; sel8 routes stimulus and observation.
// Timeout scenario is compiled in with SEQ_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_network_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               sel8;
    logic               sclk_drv;
    logic [7:0]         done_drv;
    logic signed [15:0] fin;

    logic sclk3, sclk8;
    logic [2:0] done3;
    logic [7:0] done8;
    assign sclk3 = sclk_drv & ~sel8;
    assign sclk8 = sclk_drv & sel8;
    assign done3 = sel8 ? 3'd0 : done_drv[2:0];
    assign done8 = sel8 ? done_drv : 8'd0;

    logic               lsb3, ov3, busy3, err3;
    logic [2:0]         start3;
    logic [1:0]         cache3;
    logic signed [15:0] samp3;
    logic [15:0]        ovr3, pass3;
    logic               lsb8, ov8, busy8, err8;
    logic [7:0]         start8;
    logic [6:0]         cache8;
    logic signed [15:0] samp8;
    logic [15:0]        ovr8, pass8;

    network_sequencer #(.W(16), .NUM_LAYERS(3), .CNT_W(16), .TIMEOUT(16)) dut3 (
        .clk(clk), .rst(rst), .sample_clk(sclk3), .lsb_shift(lsb3),
        .conv_start(start3), .conv_done(done3), .cache_shift(cache3),
        .final_in(fin), .sample_out(samp3), .out_valid(ov3), .busy(busy3),
        .overrun_cnt(ovr3), .pass_cycles(pass3), .error(err3)
    );

    network_sequencer #(.W(16), .NUM_LAYERS(8), .CNT_W(16), .TIMEOUT(1024)) dut8 (
        .clk(clk), .rst(rst), .sample_clk(sclk8), .lsb_shift(lsb8),
        .conv_start(start8), .conv_done(done8), .cache_shift(cache8),
        .final_in(fin), .sample_out(samp8), .out_valid(ov8), .busy(busy8),
        .overrun_cnt(ovr8), .pass_cycles(pass8), .error(err8)
    );

    logic               m_lsb, m_ov, m_busy, m_err;
    logic [7:0]         m_start;
    logic [6:0]         m_cache;
    logic signed [15:0] m_sample;
    logic [15:0]        m_ovr, m_pass;
    assign m_lsb    = sel8 ? lsb8 : lsb3;
    assign m_ov     = sel8 ? ov8 : ov3;
    assign m_busy   = sel8 ? busy8 : busy3;
    assign m_err    = sel8 ? err8 : err3;
    assign m_start  = sel8 ? start8 : {5'd0, start3};
    assign m_cache  = sel8 ? cache8 : {5'd0, cache3};
    assign m_sample = sel8 ? samp8 : samp3;
    assign m_ovr    = sel8 ? ovr8 : ovr3;
    assign m_pass   = sel8 ? pass8 : pass3;

    int checks = 0;
    int errors = 0;

    // results of the last monitored pass
    int         n_lsb, n_start, n_cache, n_ov;
    int         lsb_cyc, ov_cyc, start1_cyc, err_cyc, lat;
    bit         mon_ok;
    logic [7:0] start_seq [0:15];
    logic [6:0] cache_seq [0:15];

    // Runs cycle by cycle: drives sample_clk windows, models each conv
    // (done d-1 cycles after its start pulse is seen), records pulses.
    task automatic monitor(input int d, input int tick_a, input int tick_b, input bit ghost,
                           input int skip_layer, input int stop_start, input int max_cyc);
        int cyc;
        int pend;
        int cd;
        bit stop;
        n_lsb = 0; n_start = 0; n_cache = 0; n_ov = 0;
        lsb_cyc = -1; ov_cyc = -1; start1_cyc = -1; err_cyc = -1; lat = -1;
        mon_ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            start_seq[i] = 8'd0;
            cache_seq[i] = 7'd0;
        end
        pend = -1; cd = 0; cyc = 0; stop = 1'b0;
        while (!stop && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            sclk_drv = ((tick_a > 0) && (cyc >= tick_a) && (cyc < tick_a + 4)) ||
                       ((tick_b > 0) && (cyc >= tick_b) && (cyc < tick_b + 4));
            if (m_lsb) begin
                n_lsb++;
                if (lsb_cyc < 0) lsb_cyc = cyc;
            end
            if (m_err && err_cyc < 0) err_cyc = cyc;
            if (m_cache != 7'd0) begin
                if (n_cache < 16) cache_seq[n_cache] = m_cache;
                n_cache++;
            end
            if (m_start != 8'd0) begin
                if (n_start < 16) start_seq[n_start] = m_start;
                n_start++;
                for (int b = 0; b < 8; b++) if (m_start[b]) pend = b;
                if (pend == 1 && start1_cyc < 0) start1_cyc = cyc;
                cd = d - 1;
            end else if (pend >= 0) begin
                cd--;
            end
            done_drv = 8'd0;
            if (ghost && pend == 0) done_drv[2] = 1'b1;
            if (pend >= 0 && cd <= 0) begin
                if (pend != skip_layer) done_drv[pend] = 1'b1;
                pend = -1;
            end
            if (m_ov) begin
                n_ov++;
                ov_cyc = cyc;
                lat = ov_cyc - lsb_cyc + 2;
                stop = 1'b1; mon_ok = 1'b1;
            end else if (stop_start > 0 && n_start >= stop_start) begin
                stop = 1'b1; mon_ok = 1'b1;
            end else if (lsb_cyc > 0 && !m_busy) begin
                stop = 1'b1; mon_ok = 1'b1;
            end
        end
        sclk_drv = 1'b0;
        done_drv = 8'd0;
    endtask

    task automatic test_reset;
        sel8 = 1'b0; sclk_drv = 1'b0; done_drv = 8'd0; fin = 16'sh0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", m_busy); end
        checks++; if ({m_lsb, m_start, m_cache, m_ov} !== 17'd0) begin errors++; $display("FAIL reset_pulses got %h expected 0", {m_lsb, m_start, m_cache, m_ov}); end
        checks++; if (m_sample !== 16'sh0000) begin errors++; $display("FAIL reset_sample got %h expected 0000", m_sample); end
        checks++; if ({m_ovr, m_pass} !== 32'd0) begin errors++; $display("FAIL reset_counters got %h expected 0", {m_ovr, m_pass}); end
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_error got %0b expected 0", m_err); end
        rst = 1'b0;
    endtask

    task automatic test_single_pass;
        int pulses;
        fin = 16'sh1234;
        monitor(4, 2, 0, 1'b0, -1, 0, 200);
        checks++; if (mon_ok !== 1'b1) begin errors++; $display("FAIL single_done got %0b expected 1 (cycle budget)", mon_ok); end
        checks++; if (n_lsb !== 1) begin errors++; $display("FAIL single_lsb_count got %0d expected 1", n_lsb); end
        checks++; if (n_start !== 3) begin errors++; $display("FAIL single_start_count got %0d expected 3", n_start); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (start_seq[k] !== (8'd1 << k)) begin errors++; $display("FAIL single_start_%0d got %h expected %h", k, start_seq[k], 8'd1 << k); end
        end
        checks++; if (n_cache !== 2) begin errors++; $display("FAIL single_cache_count got %0d expected 2", n_cache); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (cache_seq[k] !== (7'd1 << k)) begin errors++; $display("FAIL single_cache_%0d got %h expected %h", k, cache_seq[k], 7'd1 << k); end
        end
        checks++; if (m_sample !== 16'sh1234) begin errors++; $display("FAIL single_sample got %h expected 1234", m_sample); end
        checks++; if (m_pass !== 16'd20) begin errors++; $display("FAIL single_pass_cycles got %0d expected 20", m_pass); end
        checks++; if (lat !== 20) begin errors++; $display("FAIL single_latency got %0d expected 20", lat); end
        checks++; if (m_ovr !== 16'd0) begin errors++; $display("FAIL single_overrun got %0d expected 0", m_ovr); end
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL single_error got %0b expected 0", m_err); end
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m_lsb || m_ov || m_busy || m_start != 8'd0 || m_cache != 7'd0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL single_quiet got %0d active cycles expected 0", pulses); end
    endtask

    task automatic test_overrun;
        fin = 16'sh8001;
        monitor(4, 2, 14, 1'b0, -1, 0, 200);
        checks++; if (mon_ok !== 1'b1) begin errors++; $display("FAIL overrun_done got %0b expected 1 (cycle budget)", mon_ok); end
        checks++; if (n_lsb !== 1) begin errors++; $display("FAIL overrun_lsb_count got %0d expected 1", n_lsb); end
        checks++; if (n_start !== 3) begin errors++; $display("FAIL overrun_start_count got %0d expected 3", n_start); end
        checks++; if (m_ovr !== 16'd1) begin errors++; $display("FAIL overrun_cnt got %0d expected 1", m_ovr); end
        checks++; if (lat !== 20) begin errors++; $display("FAIL overrun_latency got %0d expected 20", lat); end
        checks++; if (m_sample !== 16'sh8001) begin errors++; $display("FAIL overrun_sample got %h expected 8001", m_sample); end
        checks++; if (m_pass !== 16'd20) begin errors++; $display("FAIL overrun_pass_cycles got %0d expected 20", m_pass); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL overrun_no_restart got busy %0b expected 0", m_busy); end
    endtask

    task automatic test_ghost_done;
        fin = 16'sh0F0F;
        monitor(4, 2, 0, 1'b1, -1, 0, 200);
        checks++; if (mon_ok !== 1'b1) begin errors++; $display("FAIL ghost_done got %0b expected 1 (cycle budget)", mon_ok); end
        checks++; if (n_start !== 3) begin errors++; $display("FAIL ghost_start_count got %0d expected 3", n_start); end
        checks++; if (lat !== 20) begin errors++; $display("FAIL ghost_latency got %0d expected 20", lat); end
        checks++; if (m_pass !== 16'd20) begin errors++; $display("FAIL ghost_pass_cycles got %0d expected 20", m_pass); end
        checks++; if (m_sample !== 16'sh0F0F) begin errors++; $display("FAIL ghost_sample got %h expected 0f0f", m_sample); end
    endtask

    task automatic test_reset_mid_pass;
        int pulses;
        fin = 16'sh5555;
        monitor(4, 2, 0, 1'b0, -1, 2, 200);
        checks++; if (n_start !== 2 || m_busy !== 1'b1) begin errors++; $display("FAIL midrst_reach_layer1 got starts %0d busy %0b expected 2 1", n_start, m_busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b expected 0", m_busy); end
        checks++; if ({m_lsb, m_start, m_cache, m_ov} !== 17'd0) begin errors++; $display("FAIL midrst_pulses got %h expected 0", {m_lsb, m_start, m_cache, m_ov}); end
        checks++; if (m_sample !== 16'sh0000) begin errors++; $display("FAIL midrst_sample got %h expected 0000", m_sample); end
        checks++; if (m_ovr !== 16'd0 || m_pass !== 16'd0) begin errors++; $display("FAIL midrst_counters got %0d %0d expected 0 0", m_ovr, m_pass); end
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (m_lsb || m_ov || m_busy || m_start != 8'd0 || m_cache != 7'd0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles expected 0", pulses); end
        fin = 16'sh1234;
        monitor(4, 2, 0, 1'b0, -1, 0, 200);
        checks++; if (n_lsb !== 1 || n_start !== 3 || n_cache !== 2) begin errors++; $display("FAIL midrst_repass_pulses got %0d %0d %0d expected 1 3 2", n_lsb, n_start, n_cache); end
        checks++; if (m_sample !== 16'sh1234) begin errors++; $display("FAIL midrst_repass_sample got %h expected 1234", m_sample); end
        checks++; if (m_pass !== 16'd20) begin errors++; $display("FAIL midrst_repass_cycles got %0d expected 20", m_pass); end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout;
        fin = 16'sh2222;
        monitor(4, 2, 0, 1'b0, 1, 0, 300);
        checks++; if (mon_ok !== 1'b1) begin errors++; $display("FAIL timeout_done got %0b expected 1 (cycle budget)", mon_ok); end
        checks++; if (n_ov !== 0) begin errors++; $display("FAIL timeout_out_valid got %0d expected 0", n_ov); end
        checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL timeout_error got %0b expected 1", m_err); end
        checks++; if (err_cyc - start1_cyc !== 16) begin errors++; $display("FAIL timeout_wait_cycles got %0d expected 16", err_cyc - start1_cyc); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %0b expected 0", m_busy); end
        checks++; if (m_sample !== 16'sh1234) begin errors++; $display("FAIL timeout_sample got %h expected 1234", m_sample); end
        checks++; if (m_pass !== 16'd20) begin errors++; $display("FAIL timeout_pass_cycles got %0d expected 20", m_pass); end
        checks++; if (n_start !== 2 || n_cache !== 1) begin errors++; $display("FAIL timeout_pulses got %0d %0d expected 2 1", n_start, n_cache); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL timeout_error_cleared got %0b expected 0", m_err); end
    endtask
`endif

    task automatic test_eight_layers;
        sel8 = 1'b1;
        fin = 16'sh7FFF;
        monitor(1, 2, 0, 1'b0, -1, 0, 300);
        checks++; if (mon_ok !== 1'b1) begin errors++; $display("FAIL eight_done got %0b expected 1 (cycle budget)", mon_ok); end
        checks++; if (n_start !== 8) begin errors++; $display("FAIL eight_start_count got %0d expected 8", n_start); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (start_seq[k] !== (8'd1 << k)) begin errors++; $display("FAIL eight_start_%0d got %h expected %h", k, start_seq[k], 8'd1 << k); end
        end
        checks++; if (n_cache !== 7) begin errors++; $display("FAIL eight_cache_count got %0d expected 7", n_cache); end
        for (int k = 0; k < 7; k++) begin
            checks++; if (cache_seq[k] !== (7'd1 << k)) begin errors++; $display("FAIL eight_cache_%0d got %h expected %h", k, cache_seq[k], 7'd1 << k); end
        end
        checks++; if (m_pass !== 16'd26) begin errors++; $display("FAIL eight_pass_cycles got %0d expected 26", m_pass); end
        checks++; if (lat !== 26) begin errors++; $display("FAIL eight_latency got %0d expected 26", lat); end
        checks++; if (m_sample !== 16'sh7FFF) begin errors++; $display("FAIL eight_sample got %h expected 7fff", m_sample); end
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_overrun();
        test_ghost_done();
        test_reset_mid_pass();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_eight_layers();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
